// File: rtl/gray_bbox_tracker.sv
// Thresholds a raster grayscale stream and reports, once per frame, the bounding
// box and population of all pixels at or above a per-frame latched threshold.
module gray_bbox_tracker #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int COORD_W    = 10,
    parameter int CNT_W      = 17
) (
    input  logic               clk,
    input  logic               aresetn,
    input  logic [11:0]        GRAYSCALE,
    input  logic               valid_in,
    input  logic               sof_in,
    input  logic [11:0]        THRESH,
    output logic [COORD_W-1:0] X_MIN,
    output logic [COORD_W-1:0] X_MAX,
    output logic [COORD_W-1:0] Y_MIN,
    output logic [COORD_W-1:0] Y_MAX,
    output logic [CNT_W-1:0]   PIXEL_COUNT,
    output logic               found,
    output logic               frame_done
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_HEIGHT - 1);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
    state_t state_reg, state_next;

    logic [COORD_W-1:0] x_reg, x_next, y_reg, y_next;
    logic [COORD_W-1:0] xmin_reg, xmin_next, xmax_reg, xmax_next;
    logic [COORD_W-1:0] ymin_reg, ymin_next, ymax_reg, ymax_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [11:0]        thr_reg, thr_next;

    logic [COORD_W-1:0] oxmin_reg, oxmin_next, oxmax_reg, oxmax_next;
    logic [COORD_W-1:0] oymin_reg, oymin_next, oymax_reg, oymax_next;
    logic [CNT_W-1:0]   ocnt_reg, ocnt_next;
    logic               found_reg, found_next, done_reg, done_next;

    logic               accept, first, last, is_obj;
    logic [COORD_W-1:0] px, py;
    logic [COORD_W-1:0] bxmin, bxmax, bymin, bymax, cxmin, cxmax, cymin, cymax;
    logic [CNT_W-1:0]   bcnt, ccnt;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        xmin_next  = xmin_reg;
        xmax_next  = xmax_reg;
        ymin_next  = ymin_reg;
        ymax_next  = ymax_reg;
        cnt_next   = cnt_reg;
        thr_next   = thr_reg;
        oxmin_next = oxmin_reg;
        oxmax_next = oxmax_reg;
        oymin_next = oymin_reg;
        oymax_next = oymax_reg;
        ocnt_next  = ocnt_reg;
        found_next = found_reg;
        done_next  = 1'b0;

        accept = valid_in && (sof_in || state_reg == ACTIVE);
        // sof_in mid-frame restarts at (0,0) and drops the partial accumulation
        first  = sof_in || (x_reg == '0 && y_reg == '0);
        px     = sof_in ? '0 : x_reg;
        py     = sof_in ? '0 : y_reg;
        last   = (px == X_LAST) && (py == Y_LAST);

        bxmin  = first ? '1 : xmin_reg;
        bxmax  = first ? '0 : xmax_reg;
        bymin  = first ? '1 : ymin_reg;
        bymax  = first ? '0 : ymax_reg;
        bcnt   = first ? '0 : cnt_reg;
        is_obj = GRAYSCALE >= (first ? THRESH : thr_reg);

        cxmin  = (is_obj && px < bxmin) ? px : bxmin;
        cxmax  = (is_obj && px > bxmax) ? px : bxmax;
        cymin  = (is_obj && py < bymin) ? py : bymin;
        cymax  = (is_obj && py > bymax) ? py : bymax;
        ccnt   = (is_obj && bcnt != '1) ? bcnt + 1'b1 : bcnt;

        if (accept) begin
            state_next = ACTIVE;
            if (first) thr_next = THRESH;
            if (last) begin
                found_next = (ccnt != '0);
                oxmin_next = (ccnt != '0) ? cxmin : '0;
                oxmax_next = (ccnt != '0) ? cxmax : '0;
                oymin_next = (ccnt != '0) ? cymin : '0;
                oymax_next = (ccnt != '0) ? cymax : '0;
                ocnt_next  = ccnt;
                done_next  = 1'b1;
                xmin_next  = '1;
                xmax_next  = '0;
                ymin_next  = '1;
                ymax_next  = '0;
                cnt_next   = '0;
                x_next     = '0;
                y_next     = '0;
            end else begin
                xmin_next = cxmin;
                xmax_next = cxmax;
                ymin_next = cymin;
                ymax_next = cymax;
                cnt_next  = ccnt;
                x_next    = (px == X_LAST) ? '0 : px + 1'b1;
                y_next    = (px == X_LAST) ? py + 1'b1 : py;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            x_reg     <= '0;
            y_reg     <= '0;
            xmin_reg  <= '1;
            xmax_reg  <= '0;
            ymin_reg  <= '1;
            ymax_reg  <= '0;
            cnt_reg   <= '0;
            thr_reg   <= '0;
            oxmin_reg <= '0;
            oxmax_reg <= '0;
            oymin_reg <= '0;
            oymax_reg <= '0;
            ocnt_reg  <= '0;
            found_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            x_reg     <= x_next;
            y_reg     <= y_next;
            xmin_reg  <= xmin_next;
            xmax_reg  <= xmax_next;
            ymin_reg  <= ymin_next;
            ymax_reg  <= ymax_next;
            cnt_reg   <= cnt_next;
            thr_reg   <= thr_next;
            oxmin_reg <= oxmin_next;
            oxmax_reg <= oxmax_next;
            oymin_reg <= oymin_next;
            oymax_reg <= oymax_next;
            ocnt_reg  <= ocnt_next;
            found_reg <= found_next;
            done_reg  <= done_next;
        end
    end

    assign X_MIN       = oxmin_reg;
    assign X_MAX       = oxmax_reg;
    assign Y_MIN       = oymin_reg;
    assign Y_MAX       = oymax_reg;
    assign PIXEL_COUNT = ocnt_reg;
    assign found       = found_reg;
    assign frame_done  = done_reg;

endmodule

// File: doc/gray_bbox_tracker.md
# gray_bbox_tracker

Per-frame object locator that sits directly downstream of the RGB-to-grayscale stage in the object-tracking pipeline. It consumes the 12-bit grayscale pixel stream and its valid strobe, and thresholds each pixel against a programmable level. It tracks raster position and accumulates the bounding box and pixel count of all above-threshold pixels. At the end of each frame it publishes the result with a one-cycle done pulse.

## Interface
- IMG_WIDTH, 320, active pixels per line (≥2)
- IMG_HEIGHT, 240, lines per frame (≥2)
- COORD_W, 10, coordinate width; must hold max(IMG_WIDTH, IMG_HEIGHT)-1
- CNT_W, 17, pixel-count width; must hold IMG_WIDTH*IMG_HEIGHT
- clk  input  1  single clock, rising edge
- aresetn  input  1  asynchronous active-low reset
- GRAYSCALE  input  12  pixel intensity (upstream range 0..3487)
- valid_in  input  1  GRAYSCALE is a valid pixel this cycle
- sof_in  input  1  start of frame; qualified only together with valid_in, and marks that pixel as (0,0)
- THRESH  input  12  object threshold
- X_MIN, X_MAX  output  COORD_W  bounding box columns of last completed frame
- Y_MIN, Y_MAX  output  COORD_W  bounding box rows of last completed frame
- PIXEL_COUNT  output  CNT_W  number of object pixels in last completed frame
- found  output  1  last completed frame contained ≥1 object pixel
- frame_done  output  1  one-cycle pulse when outputs are updated

## Operation
- Clock and reset: one clock `clk`; reset `aresetn` is asynchronous and active-low.
- Reset: all outputs are 0, x/y counters are 0, accumulators are cleared, and the state is IDLE.
- States:
  - IDLE: waiting for the first frame; pixels without sof_in are ignored.
  - ACTIVE: accumulating a frame.
- Transitions:
  - IDLE→ACTIVE on valid_in & sof_in.
  - ACTIVE stays ACTIVE across frames; each last pixel completes the frame and the next pixel is (0,0).
- Threshold latching: THRESH is captured on the first pixel of each frame (x=0,y=0). That captured value is used for the whole frame, so mid-frame THRESH changes take effect next frame.
- Object test: a pixel is an object pixel iff GRAYSCALE ≥ threshold. The first pixel is compared against the live THRESH.
- Position counters: x increments on each accepted pixel. At x=IMG_WIDTH-1, x wraps to 0 and y increments. At (IMG_WIDTH-1, IMG_HEIGHT-1) both wrap to 0.
- Accumulation:
  - Working min registers initialise to all-ones; working max registers initialise to 0.
  - Each object pixel updates min/max with (x,y) and increments the working count.
  - The count saturates at all-ones (unreachable with correct parameters).
- Frame end, on the last pixel (including that pixel's own contribution):
  - Working values are copied to the outputs.
  - found = (count≠0).
  - If found=0, X/Y outputs are driven to 0.
  - Working registers are reinitialised.
- sof_in while ACTIVE and not at (0,0):
  - The partial frame is discarded without frame_done.
  - This pixel is treated as (0,0) of a new frame and is accumulated.
- valid_in low: counters and accumulators hold. Gaps anywhere, including mid-line, are allowed.

## Timing
- Throughput: one pixel per cycle, no backpressure.
- Latency: frame_done and the updated outputs appear the cycle after the last pixel's valid_in edge (registered). They hold until the next frame_done.
- frame_done is high for exactly one cycle per completed frame. A back-to-back next frame does not disturb it.
- Reset asserted mid-frame: everything clears immediately and the block returns to IDLE. The next frame must start with sof_in.
- Object test and min/max comparisons are fully registered within one cycle; no pipelining beyond the output register.

## Test plan
- Basic box (IMG_WIDTH=8, IMG_HEIGHT=4, THRESH=2000):
  - Stimulus: one frame with pixels (2,1),(5,1),(3,2) = 3000, all others 100.
  - Required: frame_done one cycle after the 32nd pixel, X_MIN=2, X_MAX=5, Y_MIN=1, Y_MAX=2, PIXEL_COUNT=3, found=1.
- Empty frame:
  - Stimulus: all pixels 0.
  - Required: found=0, PIXEL_COUNT=0, X/Y outputs 0, frame_done pulses once.
- Corners and boundary:
  - Stimulus: object only at (0,0) and (7,3) with GRAYSCALE=THRESH exactly.
  - Required: box 0..7 × 0..3, count 2.
- Gaps and back-to-back frames:
  - Stimulus: random valid_in gaps, then two consecutive frames with different objects.
  - Required: each frame reports its own box, exactly two frame_done pulses.
- Resync and THRESH change:
  - Stimulus: sof_in at pixel 10 of a frame, and THRESH changed mid-frame.
  - Required: no frame_done for the aborted frame; the new frame uses THRESH sampled at its first pixel.
- Reset mid-frame:
  - Stimulus: drop aresetn after 15 pixels, then pixels without sof_in, then a full frame with sof_in.
  - Required: outputs 0 during reset; pixels before sof_in are ignored; the full frame reports correctly.
